eth_tx_frame_fifo: RTL and testbench
====================================

# eth_tx_frame_fifo

Store-and-forward AXI-Stream frame FIFO on the Ethernet transmit path, between the RISC-V block design's `eth_tx_axis_*` output and the `eth0_tx_axis_*` input of the VCU118 Ethernet/QSFP28 stage. The 10G MAC must never see a mid-frame underrun, so this block releases a frame only after it has been fully received. Frames flagged bad by the sender (`tuser`) and frames too large for the buffer are discarded whole.

## Interface
Parameters:
- `DEPTH`, 512: buffer depth in 64-bit beats. Must be a power of two and at least 4. The default holds 4 KiB.
- `ADDR_W`, $clog2(DEPTH): memory address width. Pointers and counts are `ADDR_W+1` bits.

Ports:
- `clock` in 1: Ethernet GT user clock. This is the only clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `s_axis_tdata` in 64: input beat data.
- `s_axis_tkeep` in 8: byte enables. Stored and forwarded unchanged.
- `s_axis_tlast` in 1: last beat of a frame.
- `s_axis_tuser` in 1: abort. Sampled on the `tlast` beat only.
- `s_axis_tvalid` in 1: input valid.
- `s_axis_tready` out 1: input ready.
- `m_axis_tdata` out 64, `m_axis_tkeep` out 8, `m_axis_tlast` out 1: output beat.
- `m_axis_tuser` out 1: tied to 0.
- `m_axis_tvalid` out 1: output valid.
- `m_axis_tready` in 1: output ready.
- `frame_count` out ADDR_W+1: number of complete frames buffered.
- `drop` out 1: one-cycle pulse when a frame is discarded.

## Operation
- Write side:
  - `s_axis_tready`=1 in every cycle after reset. The block never backpressures; this avoids deadlock on oversize frames.
  - `wr_ptr` advances on each accepted beat while `wr_ptr - rd_ptr < DEPTH`.
  - When the buffer is full, further beats of the current frame are discarded and the frame is marked `ovf`.
- Commit, on the accepted `tlast` beat:
  - If `tuser`=0 and not `ovf`: write the beat, set `wr_commit <= wr_ptr+1`, and increment `frame_count`.
  - Otherwise: rewind `wr_ptr <= wr_commit`, clear `ovf`, and pulse `drop`.
  - A `tlast` beat that arrives while the buffer is full is treated as overflow.
- Read side:
  - The read side sees only data below `wr_commit`, so a rewind can never corrupt data being read.
  - Memory is synchronous-read, with one prefetch/output register giving first-word-fall-through behaviour.
  - The read FSM has three states:
    - IDLE: go to FETCH when `frame_count`>0.
    - FETCH: one cycle issuing the read of `rd_ptr`, then go to SEND.
    - SEND: `m_axis_tvalid`=1. On each handshake, `rd_ptr` advances and the next word is loaded.
    - On the `tlast` handshake, `frame_count` decrements. Go to SEND if another frame is committed (count after update >0), else IDLE.
- Simultaneous commit and `tlast` handshake: `frame_count` is unchanged.
- Pointer arithmetic is modulo 2^(ADDR_W+1). Wrap-around is transparent.
- Reset mid-frame: all pointers, counts and the FSM clear. Buffered and partial frames are lost. No partial frame is emitted.

## Timing
- Reset values:
  - `s_axis_tready`=0 while `resetn`=0, and 1 from the first clock edge after release.
  - `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`/`tkeep`=0.
  - `frame_count`=0, `drop`=0, FSM=IDLE.
- Latency: when `tlast` is accepted at edge N, `frame_count` reads 1 after N, and `m_axis_tvalid` is 1 after edge N+2 (the third cycle).
- `drop` is high for the one cycle after edge N when the `tlast` at N is discarded.
- Throughput: one beat per cycle on both sides. Back-to-back frames stream with no idle cycle when `m_axis_tready`=1 and the next frame is committed.
- AXI-S rules: once `m_axis_tvalid` is asserted, it and the output data hold stable until the handshake.

## Configuration
- `ETH_TX_FIFO_DROP_CNT_EN`:
  - When defined, adds output `drop_count` out 16. It increments on every `drop` pulse, saturates at 16'hFFFF, and resets to 0.
  - When undefined, the port and counter do not exist. All other behaviour is identical.

## Test plan
- 8-beat frame, `tkeep` final 8'h0F, `m_axis_tready`=1 → identical 8 beats out. `m_axis_tvalid` rises the third cycle after input `tlast`. `frame_count` goes 0→1→0.
- 3-beat frame with `tuser`=1 on `tlast` → no output, one `drop` pulse. `drop_count`=1 if enabled. A following good 2-beat frame passes intact.
- `DEPTH`=16, 20-beat frame → dropped with a `drop` pulse, `frame_count` stays 0. A subsequent 16-beat frame fills the buffer exactly and is emitted complete.
- Three 5-beat frames back-to-back with `m_axis_tready`=0 → `frame_count`=3. Then `tready`=1 → 15 contiguous output beats with no idle cycle between frames.
- Random `m_axis_tready` (50%) with a continuous input stream crossing the pointer wrap several times → output matches the scoreboard, and outputs hold stable while stalled.
- Assert `resetn`=0 midway through input and output frames → all outputs at reset values. After release, a fresh 4-beat frame passes with no stale data.

Source files
------------

// File: rtl/eth_tx_frame_fifo.sv
// -----------------------------------------------------------------------------
// eth_tx_frame_fifo
//
// Store-and-forward AXI-Stream frame FIFO for the Ethernet transmit path.
// A frame is only released to the MAC once its last beat has been received,
// so the MAC never sees a mid-frame underrun. Frames aborted by the sender
// (tuser on the tlast beat) and frames that do not fit in the buffer are
// discarded whole by rewinding the write pointer to the last commit point.
//
// Parameters:
//   DEPTH   buffer depth in 64-bit beats (power of two, >= 4)
//   ADDR_W  memory address width; pointers and counts are ADDR_W+1 bits
//
// Ports:
//   clock, resetn          single clock, asynchronous active-low reset
//   s_axis_*               input stream (tready is 1 in every cycle after reset)
//   m_axis_*               output stream, first-word-fall-through, tuser tied 0
//   frame_count            number of complete frames buffered
//   drop                   one-cycle pulse when a frame is discarded
//   drop_count             saturating count of drop pulses (optional)
//
// Optional feature macro: ETH_TX_FIFO_DROP_CNT_EN adds the drop_count output.
// -----------------------------------------------------------------------------
module eth_tx_frame_fifo #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [63:0]       s_axis_tdata,
  input  logic [7:0]        s_axis_tkeep,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tuser,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [63:0]       m_axis_tdata,
  output logic [7:0]        m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [ADDR_W:0]   frame_count,
  output logic              drop
`ifdef ETH_TX_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]       drop_count
`endif
);

  typedef logic [ADDR_W:0]   ptr_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } beat_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } rd_state_t;

  localparam ptr_t PTR_ONE   = ptr_t'(1);
  localparam ptr_t PTR_ZERO  = ptr_t'(0);
  localparam ptr_t PTR_DEPTH = ptr_t'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  beat_t     mem [DEPTH];

  ptr_t      wr_ptr;       // next write slot (may run ahead of wr_commit)
  ptr_t      wr_commit;    // end of the last committed frame
  ptr_t      rd_ptr;       // slot currently presented on the output
  ptr_t      frame_cnt_q;
  logic      ovf;          // current input frame ran out of space
  logic      ready_q;
  beat_t     out_q;        // prefetch / output register
  rd_state_t state, state_nxt;

  // ---------------------------------------------------------------------------
  // Write-side decode
  // ---------------------------------------------------------------------------
  logic  s_accept;
  logic  full;
  logic  commit;
  logic  discard;
  logic  wr_en;
  ptr_t  wr_ptr_inc;
  ptr_t  used;
  beat_t wr_beat;

  assign s_accept   = s_axis_tvalid & ready_q;
  assign used       = wr_ptr - rd_ptr;
  assign full       = (used == PTR_DEPTH);
  assign wr_ptr_inc = wr_ptr + PTR_ONE;
  assign wr_beat    = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};

  // A tlast beat arriving while full counts as overflow, so it never commits.
  assign commit  = s_accept & s_axis_tlast & ~s_axis_tuser & ~ovf & ~full;
  assign discard = s_accept & s_axis_tlast & ~commit;
  assign wr_en   = (s_accept & ~s_axis_tlast & ~full & ~ovf) | commit;

  // ---------------------------------------------------------------------------
  // Read-side decode
  // ---------------------------------------------------------------------------
  logic m_fire;
  logic rd_last;
  ptr_t rd_ptr_inc;
  ptr_t cnt_nxt;
  logic bypass;

  assign m_fire     = (state == ST_SEND) & m_axis_tready;
  assign rd_last    = m_fire & out_q.last;
  assign rd_ptr_inc = rd_ptr + PTR_ONE;
  assign cnt_nxt    = frame_cnt_q + (commit ? PTR_ONE : PTR_ZERO)
                                  - (rd_last ? PTR_ONE : PTR_ZERO);

  // A one-beat frame committed in the same cycle its predecessor's tlast is
  // taken is being written to exactly the slot we prefetch; forward it.
  assign bypass = wr_en & (wr_ptr == rd_ptr_inc);

  // ---------------------------------------------------------------------------
  // Buffer memory
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is deliberately left without a reset; only the
  // pointers need clearing, and a reset on a RAM prevents RAM inference.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[addr_t'(wr_ptr)] <= wr_beat;
    end
  end

  // ---------------------------------------------------------------------------
  // Write pointer, commit point, overflow tracking, drop pulse
  // ---------------------------------------------------------------------------
  // NOTE: all clocked state uses non-blocking assignment so every register
  // samples the pre-edge value of its sources, independent of block order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      wr_commit <= '0;
      ovf       <= 1'b0;
      drop      <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      drop    <= discard;
      if (commit) begin
        wr_ptr    <= wr_ptr_inc;
        wr_commit <= wr_ptr_inc;
      end else if (discard) begin
        wr_ptr <= wr_commit;
        ovf    <= 1'b0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr_inc;
      end else if (s_accept && full) begin
        ovf <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame counter and read pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      frame_cnt_q <= '0;
      rd_ptr      <= '0;
    end else begin
      frame_cnt_q <= cnt_nxt;
      if (m_fire) begin
        rd_ptr <= rd_ptr_inc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (frame_cnt_q != PTR_ZERO) begin
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (rd_last) begin
          state_nxt = (cnt_nxt != PTR_ZERO) ? ST_SEND : ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output register: loaded on entry to SEND and after every handshake, so the
  // next beat is ready with no bubble. Only committed slots are ever presented.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_q <= '0;
    end else if (state == ST_FETCH) begin
      out_q <= mem[addr_t'(rd_ptr)];
    end else if (m_fire) begin
      out_q <= bypass ? wr_beat : mem[addr_t'(rd_ptr_inc)];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_axis_tready = ready_q;
  assign m_axis_tvalid = (state == ST_SEND);
  assign m_axis_tdata  = out_q.data;
  assign m_axis_tkeep  = out_q.keep;
  assign m_axis_tlast  = out_q.last;
  assign m_axis_tuser  = 1'b0;
  assign frame_count   = frame_cnt_q;

`ifdef ETH_TX_FIFO_DROP_CNT_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      drop_count <= '0;
    end else if (drop && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eth_tx_frame_fifo.sv
// -----------------------------------------------------------------------------
// tb_eth_tx_frame_fifo
//
// Directed bench for eth_tx_frame_fifo with DEPTH=16. Expected output beats
// are queued by the sender for frames it knows are good; a negedge monitor
// pops and compares every output handshake and checks that stalled outputs
// hold steady.
// -----------------------------------------------------------------------------
module tb_eth_tx_frame_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } tb_beat_t;

  logic              clock;
  logic              resetn;
  logic [63:0]       s_axis_tdata;
  logic [7:0]        s_axis_tkeep;
  logic              s_axis_tlast;
  logic              s_axis_tuser;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [63:0]       m_axis_tdata;
  logic [7:0]        m_axis_tkeep;
  logic              m_axis_tlast;
  logic              m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [ADDR_W:0]   frame_count;
  logic              drop;
`ifdef ETH_TX_FIFO_DROP_CNT_EN
  logic [15:0]       drop_count;
`endif

  eth_tx_frame_fifo #(.DEPTH(DEPTH)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .frame_count   (frame_count),
    .drop          (drop)
`ifdef ETH_TX_FIFO_DROP_CNT_EN
    ,
    .drop_count    (drop_count)
`endif
  );

  int       checks   = 0;
  int       failures = 0;
  int       drops    = 0;
  int       in_beats = 0;
  int       out_beats = 0;
  tb_beat_t exp_q[$];

  logic        prev_stall = 1'b0;
  logic [63:0] prev_data  = '0;
  logic [8:0]  prev_ctl   = '0;
  logic        rand_on    = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    tb_beat_t e;
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {63'b0, m_axis_tvalid}, 64'd1);
        check("hold_data", m_axis_tdata, prev_data);
        check("hold_ctl", {55'b0, m_axis_tkeep, m_axis_tlast}, {55'b0, prev_ctl});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        out_beats++;
        check("out_tuser", {63'b0, m_axis_tuser}, 64'd0);
        if (exp_q.size() == 0) begin
          check("spurious_beat", {63'b0, m_axis_tvalid}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", m_axis_tdata, e.data);
          check("out_ctl", {55'b0, m_axis_tkeep, m_axis_tlast}, {55'b0, e.keep, e.last});
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_ctl   = {m_axis_tkeep, m_axis_tlast};
      if (drop) drops++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Sends len consecutive beats; good says whether the bench expects the frame
  // to be forwarded, in which case its beats are queued for comparison.
  task automatic send_frame(input int len, input logic bad, input logic good,
                            input logic [31:0] tag, input logic [7:0] last_keep);
    tb_beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {tag, 32'(i)};
      b.keep = (i == len - 1) ? last_keep : 8'hFF;
      b.last = (i == len - 1);
      s_axis_tdata  = b.data;
      s_axis_tkeep  = b.keep;
      s_axis_tlast  = b.last;
      s_axis_tuser  = bad & b.last;
      s_axis_tvalid = 1'b1;
      if (good) begin
        exp_q.push_back(b);
        in_beats++;
      end
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && k < budget) begin
      tick();
      k++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int k;
    resetn        = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    #2 resetn = 1'b0;

    // ---- reset values ----
    repeat (3) @(posedge clock);
    #1;
    check("rst_s_tready", {63'b0, s_axis_tready}, 64'd0);
    check("rst_m_tvalid", {63'b0, m_axis_tvalid}, 64'd0);
    check("rst_m_tlast", {63'b0, m_axis_tlast}, 64'd0);
    check("rst_m_tdata", m_axis_tdata, 64'd0);
    check("rst_m_tkeep", 64'(m_axis_tkeep), 64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    check("rst_drop", {63'b0, drop}, 64'd0);
    resetn = 1'b1;
    check("rel_tready_before_edge", {63'b0, s_axis_tready}, 64'd0);
    tick();
    check("rel_tready_after_edge", {63'b0, s_axis_tready}, 64'd1);

    // ---- test 1: 8-beat frame, latency, frame_count 0->1->0 ----
    check("t1_cnt_before", 64'(frame_count), 64'd0);
    send_frame(8, 1'b0, 1'b1, 32'hA1A1_0001, 8'h0F);
    check("t1_cnt_commit", 64'(frame_count), 64'd1);
    check("t1_valid_n0", {63'b0, m_axis_tvalid}, 64'd0);
    tick();
    check("t1_valid_n1", {63'b0, m_axis_tvalid}, 64'd0);
    tick();
    check("t1_valid_n2", {63'b0, m_axis_tvalid}, 64'd1);
    wait_drain("t1_drain", 50);
    check("t1_cnt_after", 64'(frame_count), 64'd0);

    // ---- test 2: aborted 3-beat frame, then good 2-beat frame ----
    send_frame(3, 1'b1, 1'b0, 32'hB2B2_0002, 8'hFF);
    check("t2_drop_pulse", {63'b0, drop}, 64'd1);
    check("t2_cnt", 64'(frame_count), 64'd0);
    tick();
    check("t2_drop_low", {63'b0, drop}, 64'd0);
    check("t2_drops_seen", 64'(drops), 64'd1);
`ifdef ETH_TX_FIFO_DROP_CNT_EN
    check("t2_drop_count", 64'(drop_count), 64'd1);
`endif
    send_frame(2, 1'b0, 1'b1, 32'hB2B2_0003, 8'h01);
    wait_drain("t2_drain", 50);

    // ---- test 3: oversize 20-beat frame dropped, 16-beat frame fills exactly ----
    send_frame(20, 1'b0, 1'b0, 32'hC3C3_0004, 8'hFF);
    check("t3_drop_pulse", {63'b0, drop}, 64'd1);
    check("t3_cnt", 64'(frame_count), 64'd0);
    repeat (4) tick();
    check("t3_no_valid", {63'b0, m_axis_tvalid}, 64'd0);
    check("t3_cnt_later", 64'(frame_count), 64'd0);
    check("t3_drops_seen", 64'(drops), 64'd2);
    send_frame(16, 1'b0, 1'b1, 32'hC3C3_0005, 8'h3F);
    check("t3_full_cnt", 64'(frame_count), 64'd1);
    wait_drain("t3_drain", 60);

    // ---- test 4: three 5-beat frames buffered, then streamed without gaps ----
    m_axis_tready = 1'b0;
    send_frame(5, 1'b0, 1'b1, 32'hD4D4_0006, 8'h07);
    send_frame(5, 1'b0, 1'b1, 32'hD4D4_0007, 8'h1F);
    send_frame(5, 1'b0, 1'b1, 32'hD4D4_0008, 8'h7F);
    check("t4_cnt3", 64'(frame_count), 64'd3);
    repeat (3) tick();
    check("t4_valid_stalled", {63'b0, m_axis_tvalid}, 64'd1);
    m_axis_tready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      tick();
      k++;
    end
    check("t4_stream_cycles", 64'(k), 64'd15);
    check("t4_cnt_after", 64'(frame_count), 64'd0);
    check("t4_valid_after", {63'b0, m_axis_tvalid}, 64'd0);

    // ---- test 5: random output stalls, input crosses the pointer wrap ----
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge clock);
          #1;
          m_axis_tready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int f = 0; f < 20; f++) begin
      int len;
      len = (f % 5) + 1;
      k = 0;
      while ((in_beats - out_beats + len > DEPTH - 2) && k < 200) begin
        tick();
        k++;
      end
      check("t5_space_wait", {63'b0, (k < 200)}, 64'd1);
      send_frame(len, 1'b0, 1'b1, 32'hE5E5_0100 + 32'(f), 8'hFF >> (f % 8));
    end
    wait_drain("t5_drain", 400);
    rand_on = 1'b0;
    repeat (2) tick();
    m_axis_tready = 1'b1;
    check("t5_no_drops", 64'(drops), 64'd2);
    check("t5_cnt_after", 64'(frame_count), 64'd0);

    // ---- test 6: reset in the middle of an input and an output frame ----
    m_axis_tready = 1'b0;
    send_frame(6, 1'b0, 1'b1, 32'hF6F6_0200, 8'hFF);
    repeat (3) tick();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_axis_tdata  = {32'hF6F6_0201, 32'(i)};
      s_axis_tkeep  = 8'hFF;
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b1;
      tick();
    end
    resetn        = 1'b0;
    s_axis_tvalid = 1'b0;
    #1;
    check("t6_rst_tready", {63'b0, s_axis_tready}, 64'd0);
    check("t6_rst_tvalid", {63'b0, m_axis_tvalid}, 64'd0);
    check("t6_rst_tlast", {63'b0, m_axis_tlast}, 64'd0);
    check("t6_rst_tdata", m_axis_tdata, 64'd0);
    check("t6_rst_tkeep", 64'(m_axis_tkeep), 64'd0);
    check("t6_rst_cnt", 64'(frame_count), 64'd0);
    check("t6_rst_drop", {63'b0, drop}, 64'd0);
    exp_q.delete();
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    check("t6_rel_tready", {63'b0, s_axis_tready}, 64'd1);
    repeat (4) tick();
    check("t6_no_stale_valid", {63'b0, m_axis_tvalid}, 64'd0);
    check("t6_no_stale_cnt", 64'(frame_count), 64'd0);
`ifdef ETH_TX_FIFO_DROP_CNT_EN
    check("t6_drop_count_rst", 64'(drop_count), 64'd0);
`endif
    send_frame(4, 1'b0, 1'b1, 32'h1717_0300, 8'h03);
    check("t6_cnt_commit", 64'(frame_count), 64'd1);
    wait_drain("t6_drain", 50);
    check("t6_cnt_after", 64'(frame_count), 64'd0);
    check("final_drops", 64'(drops), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
